// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running position counters, sync/blank decode,
// pixel pull handshake toward the upstream source and a one-clock registered DAC stage.
module vga_timing_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int CW       = 16
) (
    input  logic          clk_clk,
    input  logic          reset_reset,
    input  logic          enable,
    input  logic [7:0]    red_in,
    input  logic [7:0]    green_in,
    input  logic [7:0]    blue_in,
    input  logic          pixel_valid,
    output logic          pixel_req,
    output logic [CW-1:0] h_cont,
    output logic [CW-1:0] v_cont,
    output logic          frame_start,
    output logic [7:0]    vga_r,
    output logic [7:0]    vga_g,
    output logic [7:0]    vga_b,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_blank_n,
    output logic          underflow,
    input  logic          underflow_clr
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_END  = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_END  = CW'(V_SYNC);
    localparam logic [CW-1:0] H_ACT_START = CW'(H_SYNC + H_BACK);
    localparam logic [CW-1:0] H_ACT_END   = CW'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_START = CW'(V_SYNC + V_BACK);
    localparam logic [CW-1:0] V_ACT_END   = CW'(V_SYNC + V_BACK + V_ACTIVE);

    logic [CW-1:0] h_cont_reg, h_cont_next;
    logic [CW-1:0] v_cont_reg, v_cont_next;
    logic          h_wrap;
    logic          h_act, v_act;
    logic          hs_raw, vs_raw;
    logic          hs_reg, vs_reg, blank_n_reg, underflow_reg;
    logic [23:0]   rgb_in;
    logic [23:0]   rgb_out;

    // ---------------- position counters ----------------
    assign h_wrap = (h_cont_reg == H_LAST);

    always_comb begin
        h_cont_next = '0;
        v_cont_next = '0;
        if (enable) begin
            h_cont_next = h_wrap ? '0 : h_cont_reg + CW'(1);
            v_cont_next = v_cont_reg;
            if (h_wrap) begin
                v_cont_next = (v_cont_reg == V_LAST) ? '0 : v_cont_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            h_cont_reg <= '0;
            v_cont_reg <= '0;
        end else begin
            h_cont_reg <= h_cont_next;
            v_cont_reg <= v_cont_next;
        end
    end

    assign h_cont = h_cont_reg;
    assign v_cont = v_cont_reg;

    // ---------------- decode ----------------
    assign h_act  = (h_cont_reg >= H_ACT_START) && (h_cont_reg < H_ACT_END);
    assign v_act  = (v_cont_reg >= V_ACT_START) && (v_cont_reg < V_ACT_END);
    assign hs_raw = !(h_cont_reg < H_SYNC_END);
    assign vs_raw = !(v_cont_reg < V_SYNC_END);

    // Reset gating keeps these strobes quiet while reset is held with enable high.
    assign pixel_req   = !reset_reset && enable && h_act && v_act;
    assign frame_start = !reset_reset && enable && (h_cont_reg == '0) && (v_cont_reg == '0);

    // ---------------- registered output stage ----------------
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            hs_reg      <= 1'b1;
            vs_reg      <= 1'b1;
            blank_n_reg <= 1'b0;
        end else begin
            // Syncs idle high while disabled even though the counters sit at 0.
            hs_reg      <= !enable || hs_raw;
            vs_reg      <= !enable || vs_raw;
            blank_n_reg <= pixel_req;
        end
    end

    assign rgb_in = {blue_in, green_in, red_in};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic [7:0] chan_reg;
            always_ff @(posedge clk_clk or posedge reset_reset) begin
                if (reset_reset) begin
                    chan_reg <= '0;
                end else if (pixel_req && pixel_valid) begin
                    chan_reg <= rgb_in[gi*8 +: 8];
                end else begin
                    chan_reg <= '0;
                end
            end
            assign rgb_out[gi*8 +: 8] = chan_reg;
        end
    endgenerate

    assign vga_r       = rgb_out[7:0];
    assign vga_g       = rgb_out[15:8];
    assign vga_b       = rgb_out[23:16];
    assign vga_hs      = hs_reg;
    assign vga_vs      = vs_reg;
    assign vga_blank_n = blank_n_reg;

    // ---------------- sticky underflow ----------------
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            underflow_reg <= 1'b0;
        end else if (pixel_req && !pixel_valid) begin
            underflow_reg <= 1'b1;
        end else if (underflow_clr) begin
            underflow_reg <= 1'b0;
        end
    end

    assign underflow = underflow_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a reduced raster (17 x 9) so whole frames stay short;
// expected values come from a cycle-index model of the raster position.
module tb_vga_timing_gen;

    localparam int HS = 4, HB = 3, HA = 8, HF = 2;
    localparam int VS = 2, VB = 2, VA = 4, VF = 1;
    localparam int HT = HS + HB + HA + HF;   // 17
    localparam int VT = VS + VB + VA + VF;   // 9
    localparam int FR = HT * VT;             // 153
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [7:0]    red_in, green_in, blue_in;
    logic          pixel_valid;
    logic          pixel_req;
    logic [CW-1:0] h_cont, v_cont;
    logic          frame_start;
    logic [7:0]    vga_r, vga_g, vga_b;
    logic          vga_hs, vga_vs, vga_blank_n;
    logic          underflow;
    logic          underflow_clr;

    vga_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF), .CW(CW)
    ) dut (
        .clk_clk      (clk),
        .reset_reset  (rst),
        .enable       (enable),
        .red_in       (red_in),
        .green_in     (green_in),
        .blue_in      (blue_in),
        .pixel_valid  (pixel_valid),
        .pixel_req    (pixel_req),
        .h_cont       (h_cont),
        .v_cont       (v_cont),
        .frame_start  (frame_start),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .vga_hs       (vga_hs),
        .vga_vs       (vga_vs),
        .vga_blank_n  (vga_blank_n),
        .underflow    (underflow),
        .underflow_clr(underflow_clr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n        = 0;       // model raster index = v*HT + h
    int cyc      = 0;
    int fs_count = 0;
    logic       e_hs, e_vs, e_blank, e_uf;
    logic [7:0] e_r, e_g, e_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d)", tag, got, exp, n % HT, n / HT);
        end
    endtask

    function automatic logic active(input int h, input int v);
        return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    endfunction

    task automatic model_reset();
        n = 0; e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0;
        e_r = '0; e_g = '0; e_b = '0; e_uf = 1'b0;
    endtask

    // Called just after a falling edge: drive inputs, check decode, advance one clock, check state.
    task automatic tick(input logic en_n, input logic val_n, input logic clr_n);
        int h, v;
        logic preq;
        h = n % HT;
        v = n / HT;
        enable = en_n; pixel_valid = val_n; underflow_clr = clr_n;
        red_in = 8'(h); green_in = 8'(v) ^ 8'h5a; blue_in = 8'(cyc);
        cyc++;
        #1;
        preq = en_n && active(h, v);
        check("pixel_req", pixel_req, preq);
        check("frame_start", frame_start, en_n && h == 0 && v == 0);
        if (frame_start) fs_count++;
        e_hs    = !en_n || (h >= HS);
        e_vs    = !en_n || (v >= VS);
        e_blank = preq;
        e_r = (preq && val_n) ? red_in   : 8'h00;
        e_g = (preq && val_n) ? green_in : 8'h00;
        e_b = (preq && val_n) ? blue_in  : 8'h00;
        if (preq && !val_n) e_uf = 1'b1;
        else if (clr_n)     e_uf = 1'b0;
        n = en_n ? (n + 1) % FR : 0;
        @(negedge clk);
        check("h_cont", h_cont, n % HT);
        check("v_cont", v_cont, n / HT);
        check("vga_hs", vga_hs, e_hs);
        check("vga_vs", vga_vs, e_vs);
        check("vga_blank_n", vga_blank_n, e_blank);
        check("vga_r", vga_r, e_r);
        check("vga_g", vga_g, e_g);
        check("vga_b", vga_b, e_b);
        check("underflow", underflow, e_uf);
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (n != target && guard <= FR) begin
            tick(1'b1, 1'b1, 1'b0);
            guard++;
        end
        check("run_to_reached", n, target);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_h"}, h_cont, 0);
        check({tag, "_v"}, v_cont, 0);
        check({tag, "_hs"}, vga_hs, 1);
        check({tag, "_vs"}, vga_vs, 1);
        check({tag, "_blank"}, vga_blank_n, 0);
        check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
        check({tag, "_uf"}, underflow, 0);
        check({tag, "_preq"}, pixel_req, 0);
        check({tag, "_fs"}, frame_start, 0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; pixel_valid = 1'b1; underflow_clr = 1'b0;
        red_in = '0; green_in = '0; blue_in = '0;
        #3;
        check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Two full frames: wraps, frame_start once per frame, sync/blank and pixel path.
        fs_count = 0;
        for (int i = 0; i < 2 * FR; i++) tick(1'b1, 1'b1, 1'b0);
        check("frame_start_count", fs_count, 2);
        $display("two frames run, frame_start pulses=%0d", fs_count);

        // Single missing pixel at an active position, sticky into the next frame.
        run_to(5 * HT + 10);
        tick(1'b1, 1'b0, 1'b0);
        $display("underflow injected at h=10 v=5, flag=%0b", underflow);
        run_to(0);
        run_to(HT + 3);
        check("uf_sticky_next_frame", underflow, 1);
        tick(1'b1, 1'b1, 1'b1);
        $display("underflow_clr pulsed, flag=%0b", underflow);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);   // valid low outside active: ignored
        run_to(5 * HT + 10);
        tick(1'b1, 1'b0, 1'b1);                              // set beats clear
        $display("underflow with simultaneous clear, flag=%0b", underflow);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0);

        // Abort mid-frame, hold disabled, then restart a full frame from (0,0).
        run_to(6 * HT + 12);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0);
        $display("enable dropped at h=12 v=6, counters now %0d/%0d", h_cont, v_cont);
        fs_count = 0;
        for (int i = 0; i < FR; i++) tick(1'b1, 1'b1, 1'b0);
        check("reenable_frame_start_count", fs_count, 1);

        // Asynchronous reset between clock edges while mid-line with live outputs.
        run_to(4 * HT + 8);
        tick(1'b1, 1'b0, 1'b0);
        run_to(5 * HT + 10);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        $display("async reset asserted mid-line, h=%0d v=%0d", h_cont, v_cont);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2 * HT; i++) tick(1'b1, 1'b1, 1'b0);
        $display("raster restarted after reset, h=%0d v=%0d", h_cont, v_cont);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
